// File: rtl/sar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sar_pkg
// Description : Shared widths, clip bounds, FSM state type and target clip
//               helper for the SAR job dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
package sar_pkg;

    localparam int X_W   = 4;
    localparam int Y_W   = 10;
    localparam int JOB_W = Y_W + 1;

    localparam logic [Y_W-1:0] TGT_MIN = 10'd550;
    localparam logic [Y_W-1:0] TGT_MAX = 10'd1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // One FIFO entry: clipped target plus a flag recording that clipping happened
    typedef struct packed {
        logic           clipped;
        logic [Y_W-1:0] target;
    } job_t;

    // Saturate a raw target into [lo, hi] and report whether it was moved
    function automatic job_t clip_target(input logic [Y_W-1:0] raw,
                                         input logic [Y_W-1:0] lo,
                                         input logic [Y_W-1:0] hi);
        job_t j;
        if (raw < lo) begin
            j.target  = lo;
            j.clipped = 1'b1;
        end else if (raw > hi) begin
            j.target  = hi;
            j.clipped = 1'b1;
        end else begin
            j.target  = raw;
            j.clipped = 1'b0;
        end
        return j;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sar_job_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : sar_job_dispatcher_if
// Description : Target stream, SAR controller and result stream signals of
//               the job dispatcher. The slave modport is the dispatcher's
//               view; the master modport is the surrounding environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface sar_job_dispatcher_if;
    import sar_pkg::*;

    // Target input stream
    logic             in_valid;
    logic             in_ready;
    logic [Y_W-1:0]   in_target;
    // SAR controller side
    logic             sar_start;
    logic [Y_W-1:0]   sar_target;
    logic             sar_done;
    logic [X_W-1:0]   sar_x;
    logic [Y_W-1:0]   sar_y;
    // Result output stream
    logic             res_valid;
    logic             res_ready;
    logic [X_W-1:0]   res_x;
    logic [Y_W-1:0]   res_y;
    logic [Y_W-1:0]   res_target;
    logic [Y_W-1:0]   res_err;
    logic             res_clipped;
    logic             res_timeout;
    // Status
    logic             busy;

    modport slave (
        input  in_valid, in_target, sar_done, sar_x, sar_y, res_ready,
        output in_ready, sar_start, sar_target, res_valid, res_x, res_y,
               res_target, res_err, res_clipped, res_timeout, busy
    );

    modport master (
        output in_valid, in_target, sar_done, sar_x, sar_y, res_ready,
        input  in_ready, sar_start, sar_target, res_valid, res_x, res_y,
               res_target, res_err, res_clipped, res_timeout, busy
    );

endinterface
`default_nettype wire

// File: rtl/sar_target_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sar_target_fifo
// Description : Small synchronous FIFO for clipped targets. Pointers carry an
//               extra wrap bit so full and empty are distinguishable. No
//               bypass: full blocks a push even if a pop happens that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_target_fifo #(
    parameter int DEPTH = 4,   // power of two, at least 2
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_PTR_ONE = (AW+1)'(1);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign empty = (r_wptr == r_rptr);
    assign rdata = r_mem[r_rptr[AW-1:0]];

    // Pointer update; reset empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + C_PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + C_PTR_ONE;
        end
    end

    // Storage write; contents are don't-care until the pointers say otherwise
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/sar_job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : sar_job_dispatcher
// Description : Buffers clipped targets, issues one SAR job at a time, waits
//               for a rising edge of done (with watchdog), and presents the
//               captured result and absolute error on a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_job_dispatcher #(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 16,
    parameter int TGT_MIN     = 550,
    parameter int TGT_MAX     = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sar_job_dispatcher_if.slave  bus
);
    import sar_pkg::*;

    localparam int              CNT_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [Y_W-1:0]  C_LO       = Y_W'(TGT_MIN);
    localparam logic [Y_W-1:0]  C_HI       = Y_W'(TGT_MAX);

    state_t             r_state;
    state_t             w_next;
    job_t               w_push_job;
    job_t               w_pop_job;
    logic [JOB_W-1:0]   w_fifo_rdata;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_sar_start;
    logic               w_res_valid;
    logic               w_done_rise;
    logic               w_timeout_hit;
    logic [Y_W-1:0]     w_err;

    logic [CNT_W-1:0]   r_cnt;
    logic               r_done_q;
    logic [Y_W-1:0]     r_target;
    logic               r_clipped;
    logic [X_W-1:0]     r_res_x;
    logic [Y_W-1:0]     r_res_y;
    logic [Y_W-1:0]     r_res_err;
    logic               r_res_timeout;

    // Clipping happens on the way into the FIFO
    assign w_push     = bus.in_valid & ~w_full;
    assign w_push_job = clip_target(bus.in_target, C_LO, C_HI);
    assign w_pop_job  = w_fifo_rdata;

    sar_target_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (JOB_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (w_push_job),
        .pop   (w_pop),
        .rdata (w_fifo_rdata),
        .full  (w_full),
        .empty (w_empty)
    );

    // A done level left high from an earlier job must not complete this one
    assign w_done_rise   = bus.sar_done & ~r_done_q;
    assign w_timeout_hit = (r_cnt == C_CNT_LAST);
    assign w_err         = (bus.sar_y >= r_target) ? (bus.sar_y - r_target)
                                                   : (r_target - bus.sar_y);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and state-decoded controls
    always_comb begin
        w_next      = r_state;
        w_pop       = 1'b0;
        w_sar_start = 1'b0;
        w_res_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_sar_start = 1'b1;
                w_next      = ST_WAIT;
            end
            ST_WAIT: begin
                // Done and timeout together: done wins in the datapath below
                if (w_done_rise || w_timeout_hit) w_next = ST_OUT;
            end
            ST_OUT: begin
                w_res_valid = 1'b1;
                if (bus.res_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Job target, watchdog, done-edge history and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_done_q      <= 1'b0;
            r_target      <= '0;
            r_clipped     <= 1'b0;
            r_res_x       <= '0;
            r_res_y       <= '0;
            r_res_err     <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            r_done_q <= bus.sar_done;
            if (w_pop) begin
                r_target  <= w_pop_job.target;
                r_clipped <= w_pop_job.clipped;
            end
            case (r_state)
                ST_ISSUE: r_cnt <= '0;
                ST_WAIT: begin
                    if (w_done_rise) begin
                        r_res_x       <= bus.sar_x;
                        r_res_y       <= bus.sar_y;
                        r_res_err     <= w_err;
                        r_res_timeout <= 1'b0;
                    end else if (w_timeout_hit) begin
                        r_res_x       <= '0;
                        r_res_y       <= '0;
                        r_res_err     <= '0;
                        r_res_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = ~w_full;
    assign bus.sar_start   = w_sar_start;
    assign bus.sar_target  = r_target;
    assign bus.res_valid   = w_res_valid;
    assign bus.res_x       = r_res_x;
    assign bus.res_y       = r_res_y;
    assign bus.res_target  = r_target;
    assign bus.res_err     = r_res_err;
    assign bus.res_clipped = r_clipped;
    assign bus.res_timeout = r_res_timeout;
    assign bus.busy        = (r_state != ST_IDLE) | ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_sar_job_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sar_job_dispatcher
// Description : Randomized self-checking bench for sar_job_dispatcher with a
//               cycle-level scoreboard of jobs and a behavioural SAR model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_job_dispatcher;

    localparam int DEPTH = 4;
    localparam int TO    = 16;
    localparam int LO    = 550;
    localparam int HI    = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    // Cycle index; at a negedge it names the cycle being observed
    always @(posedge clk) cyc <= cyc + 1;

    sar_job_dispatcher_if bus ();

    sar_job_dispatcher #(
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TO),
        .TGT_MIN     (LO),
        .TGT_MAX     (HI)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { int tgt; bit clp; int pcyc; } job_e;
    typedef struct { int x; int d; bit lvl; } ovr_t;

    int     n_checks = 0;
    int     n_pass   = 0;

    job_e   q[$];
    ovr_t   ovr[$];
    job_e   cur;
    int     outstanding = 0;
    int     last_free   = -10;
    bit     seen_valid;
    int     exp_valid_cyc;
    logic [35:0] exp_res;

    // SAR model state for the most recent start
    int     s_n = -1;
    int     s_d;
    bit     s_lvl;
    bit     s_prevhi;
    int     s_x;

    // Inputs requested for the next observed cycle
    bit     pv = 1'b0;
    int     pt = 0;
    bit     rr = 1'b0;
    bit     acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    endtask

    function automatic job_e mk_job(input int raw, input int p);
        job_e j;
        j.tgt  = (raw < LO) ? LO : ((raw > HI) ? HI : raw);
        j.clp  = (raw < LO) || (raw > HI);
        j.pcyc = p;
        return j;
    endfunction

    function automatic int exp_start();
        int p;
        p = q[0].pcyc;
        return ((last_free > p) ? last_free : p) + 2;
    endfunction

    // Done level the SAR model drives during cycle m
    function automatic bit done_at(input int m);
        if (s_n < 0)                    return 1'b0;
        if (m <= s_n)                   return s_prevhi;
        if (s_prevhi && m == s_n + 1)   return 1'b1;
        if (s_d < 0)                    return 1'b0;
        if (s_lvl)                      return m >= s_n + s_d + 1;
        return m == s_n + s_d + 1;
    endfunction

    // Pick SAR behaviour for a newly started job and derive its expected result
    task automatic launch();
        ovr_t o;
        int   y;
        int   e;
        if (ovr.size() > 0) begin
            o = ovr.pop_front();
        end else begin
            int r;
            r     = $urandom_range(0, 9);
            o.x   = $urandom_range(0, 15);
            o.d   = (r == 0) ? -1 : ((r == 1) ? TO - 1 : $urandom_range(0, 8));
            o.lvl = $urandom_range(0, 1);
        end
        s_prevhi = bus.sar_done;
        s_n      = cyc;
        s_x      = o.x;
        s_lvl    = o.lvl;
        s_d      = (s_prevhi && o.d >= 0 && o.d < 2) ? 2 : o.d;
        outstanding = 1;
        seen_valid  = 1'b0;
        if (s_d < 0) begin
            exp_valid_cyc = s_n + TO + 1;
            exp_res = {4'd0, 10'd0, 10'(cur.tgt), 10'd0, cur.clp, 1'b1};
        end else begin
            y = 1000 - 30 * s_x;
            e = (y > cur.tgt) ? y - cur.tgt : cur.tgt - y;
            exp_valid_cyc = s_n + s_d + 2;
            exp_res = {4'(s_x), 10'(y), 10'(cur.tgt), 10'(e), cur.clp, 1'b0};
        end
    endtask

    // One observed cycle: check outputs, apply inputs, book the handshakes
    task automatic step();
        bit st;
        bit irdy;
        bit rv;
        @(negedge clk);
        st   = bus.sar_start;
        irdy = bus.in_ready;
        rv   = bus.res_valid;

        if (st) begin
            chk("start_one_job", {outstanding == 0, q.size() > 0}, 2'b11);
            if (outstanding == 0 && q.size() > 0) begin
                chk("start_cycle", cyc, exp_start());
                chk("sar_target", bus.sar_target, q[0].tgt);
                cur = q.pop_front();
                launch();
            end
        end else if (outstanding == 0 && q.size() > 0 && cyc >= exp_start()) begin
            chk("start_missing", st, 1);
        end

        if (rv) begin
            if (outstanding == 0) begin
                chk("valid_without_job", rv, 0);
            end else begin
                if (!seen_valid) begin
                    chk("result_latency", cyc, exp_valid_cyc);
                    seen_valid = 1'b1;
                end
                chk("result_fields", {bus.res_x, bus.res_y, bus.res_target, bus.res_err,
                                      bus.res_clipped, bus.res_timeout}, exp_res);
            end
        end else if (outstanding != 0) begin
            if (seen_valid || cyc > exp_valid_cyc) chk("result_valid", rv, 1);
            else chk("sar_target_hold", bus.sar_target, cur.tgt);
        end

        chk("in_ready", irdy, q.size() < DEPTH);
        chk("busy", bus.busy, (q.size() > 0) || (outstanding != 0));

        bus.in_valid  = pv;
        bus.in_target = 10'(pt);
        bus.res_ready = rr;
        bus.sar_done  = done_at(cyc);
        if (s_n >= 0 && s_d >= 0 && cyc >= s_n + s_d + 1) begin
            bus.sar_x = 4'(s_x);
            bus.sar_y = 10'(1000 - 30 * s_x);
        end else begin
            bus.sar_x = 4'($urandom);
            bus.sar_y = 10'($urandom);
        end

        acc = pv && irdy;
        if (acc) q.push_back(mk_job(pt, cyc));
        if (rv && rr && outstanding != 0) begin
            outstanding = 0;
            last_free   = cyc;
        end
    endtask

    task automatic drain();
        pv = 1'b0;
        rr = 1'b1;
        for (int i = 0; i < 800 && (q.size() > 0 || outstanding != 0); i++) step();
        chk("drain_done", q.size() + outstanding, 0);
    endtask

    task automatic push_seq(input int t);
        pv = 1'b1;
        pt = t;
        for (int i = 0; i < 40; i++) begin
            step();
            if (acc) break;
        end
        pv = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int tg[5];
        int k;
        bus.in_valid  = 1'b0;
        bus.in_target = '0;
        bus.sar_done  = 1'b0;
        bus.sar_x     = '0;
        bus.sar_y     = '0;
        bus.res_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  bus.in_ready, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_sar_start", bus.sar_start, 0);
        chk("rst_busy",      bus.busy, 0);
        chk("rst_outputs",   {bus.sar_target, bus.res_x, bus.res_y, bus.res_err,
                              bus.res_clipped, bus.res_timeout}, 0);
        rst_n     = 1'b1;
        last_free = cyc - 5;

        // In-range target, then two clipped targets
        ovr.push_back('{12, 3, 1'b0});
        ovr.push_back('{15, 3, 1'b0});
        ovr.push_back('{15, 3, 1'b0});
        rr = 1'b1;
        push_seq(630);
        push_seq(400);
        push_seq(1023);
        drain();

        // Fill the FIFO while the consumer stalls
        tg[0] = 700; tg[1] = 20; tg[2] = 1023; tg[3] = 900; tg[4] = 555;
        rr = 1'b0;
        k  = 0;
        for (int i = 0; i < 30 && k < 5; i++) begin
            pv = 1'b1;
            pt = tg[k];
            step();
            if (acc) k++;
        end
        pv = 1'b0;
        chk("fill_accepted", k, 5);
        repeat (25) step();
        chk("fill_in_ready_low", bus.in_ready, 0);
        drain();

        // Watchdog, done exactly on the last WAIT cycle, then a normal job
        ovr.push_back('{0, -1, 1'b0});
        ovr.push_back('{7, TO - 1, 1'b0});
        ovr.push_back('{3, 2, 1'b0});
        rr = 1'b1;
        push_seq(800);
        push_seq(601);
        push_seq(1000);
        drain();

        // Done held high between jobs
        ovr.push_back('{5, 0, 1'b1});
        ovr.push_back('{9, 0, 1'b1});
        ovr.push_back('{2, 4, 1'b1});
        push_seq(560);
        push_seq(990);
        push_seq(700);
        drain();

        // Random traffic
        for (int i = 0; i < 900; i++) begin
            pv = ($urandom_range(0, 99) < 55);
            pt = $urandom_range(0, 1023);
            rr = ($urandom_range(0, 99) < 70);
            step();
        end
        drain();

        // Reset in the middle of WAIT with jobs still queued
        ovr.push_back('{0, -1, 1'b0});
        rr = 1'b0;
        push_seq(750);
        push_seq(640);
        push_seq(880);
        for (int i = 0; i < 40 && !(outstanding != 0 && cyc >= s_n + 5); i++) step();
        chk("reset_job_in_wait", outstanding, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_sar_start", bus.sar_start, 0);
        chk("midrst_res_valid", bus.res_valid, 0);
        chk("midrst_in_ready",  bus.in_ready, 1);
        chk("midrst_busy",      bus.busy, 0);
        q.delete();
        ovr.delete();
        outstanding   = 0;
        s_n           = -1;
        pv            = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sar_done  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        last_free = cyc - 5;
        rr        = 1'b1;
        repeat (30) step();
        for (int i = 0; i < 150; i++) begin
            pv = ($urandom_range(0, 99) < 40);
            pt = $urandom_range(0, 1023);
            rr = ($urandom_range(0, 99) < 80);
            step();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
